// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access unit: alignment check, store byte-lane steering,
// req/ack handshake with data memory and pipeline stall generation.

package dm_pkg;

  localparam int RNG_64 = 64;

  localparam logic [1:0] B  = 2'd0;
  localparam logic [1:0] HW = 2'd1;
  localparam logic [1:0] W  = 2'd2;
  localparam logic [1:0] DW = 2'd3;

  typedef struct packed {
    logic              is_valid;
    logic [RNG_64-1:0] pc;
    logic [4:0]        rd_addr;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic [1:0]        mem_req_unit;
    logic [RNG_64-1:0] mem_addr;
    logic [RNG_64-1:0] mem_data;
  } interconnection_struct;

endpackage

module dm_access_unit
  import dm_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  interconnection_struct i_struct,
  input  logic                 i_flush,
  output logic                 o_dm_req,
  output logic                 o_dm_we,
  output logic [RNG_64-1:0]    o_dm_addr,
  output logic [RNG_64-1:0]    o_dm_wdata,
  output logic [7:0]           o_dm_be,
  input  logic                 i_dm_ack,
  input  logic [RNG_64-1:0]    i_dm_rdata,
  output logic                 o_stall,
  output interconnection_struct o_struct,
  output logic [RNG_64-1:0]    o_dm_data,
  output logic                 o_miss_aligned_error
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]            state;
  logic                  mem_op;
  logic                  is_store;
  logic                  aligned;
  logic                  accept;
  logic [2:0]            k;
  logic [7:0]            be_next;
  logic [RNG_64-1:0]     wdata_next;
  logic                  flush_seen;
  interconnection_struct req_struct;
  interconnection_struct pass_struct;
  interconnection_struct idle_bubble;
  interconnection_struct wait_bubble;
  interconnection_struct done_struct;

  assign mem_op   = i_struct.is_valid & (i_struct.mem_rd | i_struct.mem_wr) & ~i_flush;
  assign is_store = i_struct.mem_wr;
  assign k        = i_struct.mem_addr[2:0];
  assign accept   = mem_op & aligned;

  always_comb begin
    aligned = 1'b1;
    case (i_struct.mem_req_unit)
      B:       aligned = 1'b1;
      HW:      aligned = (i_struct.mem_addr[0] == 1'b0);
      W:       aligned = (i_struct.mem_addr[1:0] == 2'b00);
      default: aligned = (i_struct.mem_addr[2:0] == 3'b000);
    endcase
  end

  // Store data is shifted onto the byte lanes selected by the low address bits;
  // loads always fetch the whole doubleword and let the load controller extract.
  always_comb begin
    be_next    = 8'hFF;
    wdata_next = '0;
    if (is_store) begin
      case (i_struct.mem_req_unit)
        B: begin
          be_next    = 8'h01 << k;
          wdata_next = {56'd0, i_struct.mem_data[7:0]} << {k, 3'b000};
        end
        HW: begin
          be_next    = 8'h03 << k;
          wdata_next = {48'd0, i_struct.mem_data[15:0]} << {k, 3'b000};
        end
        W: begin
          be_next    = 8'h0F << k;
          wdata_next = {32'd0, i_struct.mem_data[31:0]} << {k, 3'b000};
        end
        default: begin
          be_next    = 8'hFF;
          wdata_next = i_struct.mem_data;
        end
      endcase
    end
  end

  always_comb begin
    pass_struct          = i_struct;
    pass_struct.is_valid = i_struct.is_valid & ~i_flush;
    idle_bubble          = i_struct;
    idle_bubble.is_valid = 1'b0;
    wait_bubble          = req_struct;
    wait_bubble.is_valid = 1'b0;
    done_struct          = req_struct;
    done_struct.is_valid = req_struct.is_valid & ~(flush_seen | i_flush);
  end

  assign o_stall = (state == IDLE) ? accept : ~i_dm_ack;

  // A flush while waiting cannot abort the bus transaction, so it is remembered
  // and only applied to the struct emitted when the ack finally arrives.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                <= IDLE;
      o_dm_req             <= 1'b0;
      o_dm_we              <= 1'b0;
      o_dm_addr            <= '0;
      o_dm_wdata           <= '0;
      o_dm_be              <= '0;
      o_dm_data            <= '0;
      o_miss_aligned_error <= 1'b0;
      o_struct             <= '0;
      req_struct           <= '0;
      flush_seen           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_dm_data <= '0;
          if (accept) begin
            state                <= WAIT;
            o_dm_req             <= 1'b1;
            o_dm_we              <= is_store;
            o_dm_addr            <= {i_struct.mem_addr[RNG_64-1:3], 3'b000};
            o_dm_wdata           <= wdata_next;
            o_dm_be              <= be_next;
            req_struct           <= i_struct;
            flush_seen           <= 1'b0;
            o_struct             <= idle_bubble;
            o_miss_aligned_error <= 1'b0;
          end else if (mem_op) begin
            o_struct             <= i_struct;
            o_miss_aligned_error <= 1'b1;
          end else begin
            o_struct             <= pass_struct;
            o_miss_aligned_error <= 1'b0;
          end
        end
        WAIT: begin
          o_miss_aligned_error <= 1'b0;
          if (i_dm_ack) begin
            state      <= IDLE;
            o_dm_req   <= 1'b0;
            o_struct   <= done_struct;
            o_dm_data  <= o_dm_we ? '0 : i_dm_rdata;
            flush_seen <= 1'b0;
          end else begin
            o_struct   <= wait_bubble;
            o_dm_data  <= '0;
            flush_seen <= flush_seen | i_flush;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Testbench for dm_access_unit: table-driven vectors with an output scoreboard,
// plus hand-written sequences for flush-in-wait, reset-in-wait and stray acks.

module tb_dm_access_unit;
  import dm_pkg::*;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  interconnection_struct i_struct;
  logic                  i_flush;
  logic                  o_dm_req;
  logic                  o_dm_we;
  logic [63:0]           o_dm_addr;
  logic [63:0]           o_dm_wdata;
  logic [7:0]            o_dm_be;
  logic                  i_dm_ack;
  logic [63:0]           i_dm_rdata;
  logic                  o_stall;
  interconnection_struct o_struct;
  logic [63:0]           o_dm_data;
  logic                  o_miss_aligned_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic        err;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    interconnection_struct s;
    logic        flush;
    int          delay;
    logic [63:0] rdata;
    logic        acc;
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        err;
    logic        out;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t popped;

  dm_access_unit dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_struct             (i_struct),
    .i_flush              (i_flush),
    .o_dm_req             (o_dm_req),
    .o_dm_we              (o_dm_we),
    .o_dm_addr            (o_dm_addr),
    .o_dm_wdata           (o_dm_wdata),
    .o_dm_be              (o_dm_be),
    .i_dm_ack             (i_dm_ack),
    .i_dm_rdata           (i_dm_rdata),
    .o_stall              (o_stall),
    .o_struct             (o_struct),
    .o_dm_data            (o_dm_data),
    .o_miss_aligned_error (o_miss_aligned_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic interconnection_struct mk_s(input logic valid, input logic rd, input logic wr,
                                                 input logic [1:0] unit, input logic [63:0] addr,
                                                 input logic [63:0] data, input logic [63:0] pc);
    interconnection_struct s;
    s              = '0;
    s.is_valid     = valid;
    s.mem_rd       = rd;
    s.mem_wr       = wr;
    s.mem_req_unit = unit;
    s.mem_addr     = addr;
    s.mem_data     = data;
    s.pc           = pc;
    s.rd_addr      = pc[6:2];
    s.reg_wr       = rd;
    return s;
  endfunction

  function automatic vec_t mk_v(input interconnection_struct s, input logic flush, input int delay,
                                input logic [63:0] rdata, input logic acc, input logic we,
                                input logic [63:0] addr, input logic [7:0] be, input logic [63:0] wdata,
                                input logic err, input logic out);
    vec_t v;
    v.s = s; v.flush = flush; v.delay = delay; v.rdata = rdata; v.acc = acc; v.we = we;
    v.addr = addr; v.be = be; v.wdata = wdata; v.err = err; v.out = out;
    return v;
  endfunction

  // Pops the scoreboard whenever the DUT presents a valid or error result.
  always @(posedge i_clk) begin
    #1;
    if (o_struct.is_valid || o_miss_aligned_error) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got output pc %h expected none", o_struct.pc);
      end else begin
        popped = sb.pop_front();
        check_output("out_pc", o_struct.pc, popped.pc);
        check_output("out_err", o_miss_aligned_error, popped.err);
        check_output("out_data", o_dm_data, popped.data);
      end
    end
  end

  task automatic apply_stimulus(input vec_t v);
    int stalls;
    @(negedge i_clk);
    i_struct   = v.s;
    i_flush    = v.flush;
    i_dm_ack   = 1'b0;
    i_dm_rdata = v.rdata;
    #1;
    check_output("stall_accept", o_stall, v.acc);
    if (v.out)
      sb.push_back('{pc: v.s.pc, err: v.err, data: (v.acc && !v.we) ? v.rdata : 64'd0});
    stalls = o_stall ? 1 : 0;
    @(posedge i_clk);
    #1;
    if (v.acc) begin
      check_output("req_on", o_dm_req, 1'b1);
      check_output("req_we", o_dm_we, v.we);
      check_output("req_addr", o_dm_addr, v.addr);
      check_output("req_be", o_dm_be, v.be);
      check_output("req_wdata", o_dm_wdata, v.wdata);
      for (int w = 1; w <= v.delay; w++) begin
        @(negedge i_clk);
        i_flush  = 1'b0;
        i_dm_ack = (w == v.delay);
        #1;
        check_output("req_held", o_dm_req, 1'b1);
        check_output("stall_wait", o_stall, (w != v.delay));
        if (o_stall) stalls++;
        @(posedge i_clk);
        #1;
      end
      check_output("req_drop", o_dm_req, 1'b0);
      check_output("stall_count", stalls, v.delay);
    end else begin
      check_output("no_req", o_dm_req, 1'b0);
    end
  endtask

  initial begin
    i_rst      = 1'b1;
    i_struct   = '0;
    i_flush    = 1'b0;
    i_dm_ack   = 1'b0;
    i_dm_rdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check_output("rst_req", o_dm_req, 1'b0);
    check_output("rst_we", o_dm_we, 1'b0);
    check_output("rst_addr", o_dm_addr, 64'd0);
    check_output("rst_wdata", o_dm_wdata, 64'd0);
    check_output("rst_be", o_dm_be, 8'd0);
    check_output("rst_data", o_dm_data, 64'd0);
    check_output("rst_err", o_miss_aligned_error, 1'b0);
    check_output("rst_struct_zero", (o_struct == '0), 1'b1);
    check_output("rst_stall", o_stall, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;

    vecs.push_back(mk_v(mk_s(1,0,0,B, 64'h0,    64'h0, 64'h100), 0,0,64'h0, 0,0,64'h0,0,64'h0, 0,1));
    vecs.push_back(mk_v(mk_s(1,1,0,DW,64'h1000, 64'h0, 64'h104), 0,4,64'h1122334455667788,
                        1,0,64'h1000,8'hFF,64'h0, 0,1));
    vecs.push_back(mk_v(mk_s(1,0,1,B, 64'h2005, 64'hAB, 64'h108), 0,1,64'h0,
                        1,1,64'h2000,8'h20,64'h0000AB0000000000, 0,1));
    vecs.push_back(mk_v(mk_s(1,1,0,W, 64'h3002, 64'h0, 64'h10C), 0,0,64'h0, 0,0,64'h0,0,64'h0, 1,1));
    vecs.push_back(mk_v(mk_s(1,0,0,B, 64'h0,    64'h0, 64'h110), 0,0,64'h0, 0,0,64'h0,0,64'h0, 0,1));
    vecs.push_back(mk_v(mk_s(1,0,1,HW,64'h40,   64'h123456789ABCBEEF, 64'h114), 0,2,64'h0,
                        1,1,64'h40,8'h03,64'h000000000000BEEF, 0,1));
    vecs.push_back(mk_v(mk_s(1,0,0,B, 64'h0,    64'h0, 64'h118), 0,0,64'h0, 0,0,64'h0,0,64'h0, 0,1));
    vecs.push_back(mk_v(mk_s(1,0,1,W, 64'h44,   64'hDEADBEEFCAFEF00D, 64'h11C), 0,1,64'h0,
                        1,1,64'h40,8'hF0,64'hCAFEF00D00000000, 0,1));
    vecs.push_back(mk_v(mk_s(1,0,1,HW,64'h46,   64'hFFFFFFFFFFFF1234, 64'h120), 0,1,64'h0,
                        1,1,64'h40,8'hC0,64'h1234000000000000, 0,1));
    vecs.push_back(mk_v(mk_s(1,1,0,HW,64'h47,   64'h0, 64'h124), 0,0,64'h0, 0,0,64'h0,0,64'h0, 1,1));
    vecs.push_back(mk_v(mk_s(1,1,0,DW,64'h4C,   64'h0, 64'h128), 0,0,64'h0, 0,0,64'h0,0,64'h0, 1,1));
    vecs.push_back(mk_v(mk_s(0,1,0,DW,64'h80,   64'h0, 64'h12C), 0,0,64'h0, 0,0,64'h0,0,64'h0, 0,0));
    vecs.push_back(mk_v(mk_s(1,1,0,B, 64'h7,    64'h0, 64'h130), 0,3,64'h00000000000000A5,
                        1,0,64'h0,8'hFF,64'h0, 0,1));
    vecs.push_back(mk_v(mk_s(1,0,1,DW,64'h88,   64'h0102030405060708, 64'h134), 0,2,64'h0,
                        1,1,64'h88,8'hFF,64'h0102030405060708, 0,1));
    vecs.push_back(mk_v(mk_s(1,1,1,W, 64'h10,   64'hFFFFFFFF00000055, 64'h138), 0,1,64'hFFFF,
                        1,1,64'h10,8'h0F,64'h0000000000000055, 0,1));
    vecs.push_back(mk_v(mk_s(1,1,0,DW,64'h200,  64'h0, 64'h13C), 1,0,64'h0, 0,0,64'h0,0,64'h0, 0,0));
    vecs.push_back(mk_v(mk_s(1,0,0,B, 64'h0,    64'h0, 64'h140), 1,0,64'h0, 0,0,64'h0,0,64'h0, 0,0));
    vecs.push_back(mk_v(mk_s(1,1,0,W, 64'h3,    64'h0, 64'h144), 1,0,64'h0, 0,0,64'h0,0,64'h0, 0,0));

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);

    // Flush pulsed mid-transaction: the access completes but the result is killed.
    @(negedge i_clk);
    i_struct   = mk_s(1,1,0,DW,64'h500,64'h0,64'h500);
    i_flush    = 1'b0;
    i_dm_ack   = 1'b0;
    i_dm_rdata = 64'h000000000000CAFE;
    #1;
    check_output("fl_stall", o_stall, 1'b1);
    @(posedge i_clk); #1;
    check_output("fl_req", o_dm_req, 1'b1);
    @(negedge i_clk);
    i_flush = 1'b1;
    #1;
    check_output("fl_stall_hold", o_stall, 1'b1);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    i_flush = 1'b0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    i_dm_ack = 1'b1;
    #1;
    check_output("fl_stall_ack", o_stall, 1'b0);
    @(posedge i_clk); #1;
    check_output("fl_valid", o_struct.is_valid, 1'b0);
    check_output("fl_pc", o_struct.pc, 64'h500);
    check_output("fl_req_drop", o_dm_req, 1'b0);
    apply_stimulus(mk_v(mk_s(1,1,0,DW,64'h508,64'h0,64'h508), 0,1,64'h77,
                        1,0,64'h508,8'hFF,64'h0, 0,1));

    // Reset while waiting for ack abandons the transaction.
    @(negedge i_clk);
    i_struct = mk_s(1,1,0,DW,64'h600,64'h0,64'h600);
    i_dm_ack = 1'b0;
    @(posedge i_clk); #1;
    check_output("rw_req", o_dm_req, 1'b1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check_output("rw_req_off", o_dm_req, 1'b0);
    check_output("rw_addr", o_dm_addr, 64'd0);
    check_output("rw_be", o_dm_be, 8'd0);
    check_output("rw_data", o_dm_data, 64'd0);
    check_output("rw_err", o_miss_aligned_error, 1'b0);
    check_output("rw_struct_zero", (o_struct == '0), 1'b1);
    @(negedge i_clk);
    i_rst    = 1'b0;
    i_struct = '0;
    apply_stimulus(mk_v(mk_s(1,1,0,DW,64'h700,64'h0,64'h700), 0,2,64'h0F0F0F0F0F0F0F0F,
                        1,0,64'h700,8'hFF,64'h0, 0,1));

    // A stray ack while idle must not start or stall anything.
    @(negedge i_clk);
    i_struct = mk_s(1,0,0,B,64'h0,64'h0,64'h800);
    i_dm_ack = 1'b1;
    sb.push_back('{pc: 64'h800, err: 1'b0, data: 64'd0});
    #1;
    check_output("ia_stall", o_stall, 1'b0);
    @(posedge i_clk); #1;
    check_output("ia_req", o_dm_req, 1'b0);
    @(negedge i_clk);
    i_dm_ack = 1'b0;
    i_struct = '0;
    repeat (3) @(posedge i_clk);
    #2;
    check_output("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
